// File: rtl/if_id_bundle_buffer.sv
// Fetch-to-decode bundle buffer: one main bundle register plus a one-bundle skid slot.
// Decode takes an in-order lane count each cycle and the remaining lanes compact toward lane 0.
module if_id_bundle_buffer #(
  parameter int LANES = 4,
  parameter int W     = 64,
  parameter int CNT_W = $clog2(LANES + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 stall,
  input  logic                 in_valid,
  input  logic [LANES-1:0]     in_mask,
  input  logic [LANES*W-1:0]   in_data,
  output logic                 in_ready,
  output logic [LANES-1:0]     out_mask,
  output logic [LANES*W-1:0]   out_data,
  input  logic [CNT_W-1:0]     consume,
  output logic                 overconsume_err
);

  logic [LANES-1:0]   main_mask_reg, main_mask_next;
  logic [LANES*W-1:0] main_data_reg, main_data_next;
  logic               skid_valid_reg, skid_valid_next;
  logic [LANES-1:0]   skid_mask_reg, skid_mask_next;
  logic [LANES*W-1:0] skid_data_reg, skid_data_next;
  logic               err_reg, err_next;

  logic [LANES-1:0]   san_mask;
  logic [LANES*W-1:0] san_data;
  logic [CNT_W-1:0]   main_cnt;
  logic [CNT_W-1:0]   k_eff;
  logic               over;
  logic [LANES-1:0]   rem_mask;
  logic [LANES*W-1:0] rem_data;
  logic               take;

  // Keep only the contiguous valid prefix from lane 0; dropped lanes carry zero data.
  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_san
      if (gi == 0) begin : g_first
        assign san_mask[gi] = in_mask[gi];
      end else begin : g_rest
        assign san_mask[gi] = in_mask[gi] & san_mask[gi-1];
      end
      assign san_data[gi*W +: W] = san_mask[gi] ? in_data[gi*W +: W] : '0;
    end
  endgenerate

  always_comb begin
    main_cnt = '0;
    for (int i = 0; i < LANES; i++) begin
      main_cnt = main_cnt + CNT_W'(main_mask_reg[i]);
    end
  end

  assign over  = !stall && (consume > main_cnt);
  assign k_eff = stall ? '0 : (over ? main_cnt : consume);

  // Logical right shifts compact the leftover lanes and zero-fill the vacated top lanes.
  assign rem_mask = main_mask_reg >> k_eff;
  assign rem_data = main_data_reg >> (k_eff * W);

  assign take = in_valid && in_ready && (|san_mask);

  always_comb begin
    main_mask_next  = main_mask_reg;
    main_data_next  = main_data_reg;
    skid_valid_next = skid_valid_reg;
    skid_mask_next  = skid_mask_reg;
    skid_data_next  = skid_data_reg;
    err_next        = err_reg;
    if (flush) begin
      main_mask_next  = '0;
      main_data_next  = '0;
      skid_valid_next = 1'b0;
      skid_mask_next  = '0;
      skid_data_next  = '0;
    end else begin
      err_next = err_reg | over;
      if (|rem_mask) begin
        main_mask_next = rem_mask;
        main_data_next = rem_data;
        if (take) begin
          skid_valid_next = 1'b1;
          skid_mask_next  = san_mask;
          skid_data_next  = san_data;
        end
      end else if (skid_valid_reg) begin
        main_mask_next  = skid_mask_reg;
        main_data_next  = skid_data_reg;
        skid_valid_next = 1'b0;
        skid_mask_next  = '0;
        skid_data_next  = '0;
      end else if (take) begin
        main_mask_next = san_mask;
        main_data_next = san_data;
      end else begin
        main_mask_next = '0;
        main_data_next = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      main_mask_reg  <= '0;
      main_data_reg  <= '0;
      skid_valid_reg <= 1'b0;
      skid_mask_reg  <= '0;
      skid_data_reg  <= '0;
      err_reg        <= 1'b0;
    end else begin
      main_mask_reg  <= main_mask_next;
      main_data_reg  <= main_data_next;
      skid_valid_reg <= skid_valid_next;
      skid_mask_reg  <= skid_mask_next;
      skid_data_reg  <= skid_data_next;
      err_reg        <= err_next;
    end
  end

  assign in_ready        = !skid_valid_reg;
  assign out_mask        = main_mask_reg;
  assign out_data        = main_data_reg;
  assign overconsume_err = err_reg;

endmodule

// File: tb/tb_if_id_bundle_buffer.sv
// Directed bench for if_id_bundle_buffer: hand-computed masks, lane data and flags after each cycle.
module tb_if_id_bundle_buffer;
  localparam int LANES = 4;
  localparam int W     = 64;
  localparam int CNT_W = 3;

  logic               clk = 1'b0;
  logic               rst, flush, stall, in_valid;
  logic [LANES-1:0]   in_mask;
  logic [LANES*W-1:0] in_data;
  logic               in_ready;
  logic [LANES-1:0]   out_mask;
  logic [LANES*W-1:0] out_data;
  logic [CNT_W-1:0]   consume;
  logic               overconsume_err;

  int checks   = 0;
  int failures = 0;
  int cycle    = 0;

  localparam logic [W-1:0] LA = 64'hAAAA_0000_0000_000A, LB = 64'hBBBB_0000_0000_000B;
  localparam logic [W-1:0] LC = 64'hCCCC_0000_0000_000C, LD = 64'hDDDD_0000_0000_000D;
  localparam logic [W-1:0] LE = 64'hEEEE_0000_0000_000E, LF = 64'hFFFF_0000_0000_000F;
  localparam logic [W-1:0] LG = 64'h1111_0000_0000_0001, LH = 64'h2222_0000_0000_0002;
  localparam logic [W-1:0] LP = 64'h3333_0000_0000_0003, LQ = 64'h4444_0000_0000_0004;
  localparam logic [W-1:0] LR = 64'h5555_0000_0000_0005, LS = 64'h6666_0000_0000_0006;

  if_id_bundle_buffer #(.LANES(LANES), .W(W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .flush(flush), .stall(stall),
    .in_valid(in_valid), .in_mask(in_mask), .in_data(in_data), .in_ready(in_ready),
    .out_mask(out_mask), .out_data(out_data), .consume(consume),
    .overconsume_err(overconsume_err)
  );

  always #5 clk = ~clk;

  function automatic logic [LANES*W-1:0] bundle(input logic [W-1:0] l0, l1, l2, l3);
    return {l3, l2, l1, l0};
  endfunction

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One clock edge; outputs are then sampled 1 time unit later.
  task automatic step(input string what);
    @(posedge clk);
    #1;
    cycle++;
    $display("txn %0d %s: out_mask=%b in_ready=%b err=%b", cycle, what, out_mask, in_ready, overconsume_err);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; stall = 1'b0; in_valid = 1'b0;
    in_mask = '0; in_data = '0; consume = '0;
    step("reset");
    step("reset");
    rst = 1'b0;
    check_eq("rst_mask", 256'(out_mask), 256'(0));
    check_eq("rst_data", 256'(out_data), 256'(0));
    check_eq("rst_ready", 256'(in_ready), 256'(1));
    check_eq("rst_err", 256'(overconsume_err), 256'(0));

    // Full bundle into an empty buffer appears after one cycle.
    in_valid = 1'b1; in_mask = 4'b1111; in_data = bundle(LA, LB, LC, LD); consume = 0;
    step("load ABCD");
    in_valid = 1'b0;
    check_eq("load_mask", 256'(out_mask), 256'(4'b1111));
    check_eq("load_data", 256'(out_data), 256'(bundle(LA, LB, LC, LD)));
    check_eq("load_ready", 256'(in_ready), 256'(1));

    consume = 1; step("consume 1");
    check_eq("c1_mask", 256'(out_mask), 256'(4'b0111));
    check_eq("c1_data", 256'(out_data), 256'(bundle(LB, LC, LD, 64'h0)));
    consume = 2; step("consume 2");
    check_eq("c2_mask", 256'(out_mask), 256'(4'b0001));
    check_eq("c2_data", 256'(out_data), 256'(bundle(LD, 64'h0, 64'h0, 64'h0)));
    consume = 1; step("consume 1");
    check_eq("c3_mask", 256'(out_mask), 256'(4'b0000));
    check_eq("c3_data", 256'(out_data), 256'(0));
    check_eq("c3_err", 256'(overconsume_err), 256'(0));

    // Stall: second bundle goes to skid, third is refused.
    in_valid = 1'b1; in_mask = 4'b1111; in_data = bundle(LA, LB, LC, LD); consume = 0;
    step("load ABCD");
    stall = 1'b1; consume = 4; in_data = bundle(LE, LF, LG, LH);
    step("stall offer EFGH");
    check_eq("stall_mask", 256'(out_mask), 256'(4'b1111));
    check_eq("stall_data", 256'(out_data), 256'(bundle(LA, LB, LC, LD)));
    check_eq("stall_ready", 256'(in_ready), 256'(0));
    in_data = bundle(LP, LQ, LR, LS);
    step("stall offer PQRS");
    check_eq("stall2_data", 256'(out_data), 256'(bundle(LA, LB, LC, LD)));
    check_eq("stall2_ready", 256'(in_ready), 256'(0));
    in_valid = 1'b0; stall = 1'b0; consume = 4;
    step("drain to skid");
    check_eq("skid_mask", 256'(out_mask), 256'(4'b1111));
    check_eq("skid_data", 256'(out_data), 256'(bundle(LE, LF, LG, LH)));
    check_eq("skid_ready", 256'(in_ready), 256'(1));
    check_eq("stall_err", 256'(overconsume_err), 256'(0));
    step("drain EFGH");
    check_eq("no_third_mask", 256'(out_mask), 256'(0));

    // Non-prefix mask is sanitised; empty mask is discarded.
    in_valid = 1'b1; in_mask = 4'b1011; in_data = bundle(LP, LQ, LR, LS); consume = 0;
    step("load 1011");
    check_eq("san_mask", 256'(out_mask), 256'(4'b0011));
    check_eq("san_data", 256'(out_data), 256'(bundle(LP, LQ, 64'h0, 64'h0)));
    in_mask = 4'b0000; in_data = bundle(LE, LF, LG, LH);
    step("offer empty");
    in_valid = 1'b0;
    check_eq("empty_mask", 256'(out_mask), 256'(4'b0011));
    check_eq("empty_data", 256'(out_data), 256'(bundle(LP, LQ, 64'h0, 64'h0)));
    check_eq("empty_ready", 256'(in_ready), 256'(1));

    // Overconsume: drains and sets the sticky flag, which survives flush.
    consume = 3; step("overconsume");
    consume = 0;
    check_eq("oc_mask", 256'(out_mask), 256'(0));
    check_eq("oc_err", 256'(overconsume_err), 256'(1));
    flush = 1'b1; step("flush");
    flush = 1'b0;
    check_eq("oc_flush_err", 256'(overconsume_err), 256'(1));

    // Flush with main and skid full, bundle offered and consume pending.
    in_valid = 1'b1; in_mask = 4'b1111; in_data = bundle(LA, LB, LC, LD);
    step("load ABCD");
    in_data = bundle(LE, LF, LG, LH);
    step("load EFGH to skid");
    check_eq("full_ready", 256'(in_ready), 256'(0));
    flush = 1'b1; consume = 2; in_data = bundle(LP, LQ, LR, LS);
    step("flush full");
    flush = 1'b0; in_valid = 1'b0; consume = 0;
    check_eq("fl_mask", 256'(out_mask), 256'(0));
    check_eq("fl_data", 256'(out_data), 256'(0));
    check_eq("fl_ready", 256'(in_ready), 256'(1));
    step("idle");
    check_eq("fl_idle_mask", 256'(out_mask), 256'(0));
    check_eq("fl_idle_err", 256'(overconsume_err), 256'(1));

    rst = 1'b1; step("reset");
    rst = 1'b0;
    check_eq("rst2_err", 256'(overconsume_err), 256'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
